// File: rtl/key_event_pkg.sv
// key_event_pkg: channel FSM state encoding and default timing constants
// shared by key_event_decoder and key_debounce_fsm.
package key_event_pkg;

  typedef enum logic [1:0] {
    UP,
    PRESS_WAIT,
    DOWN,
    REL_WAIT
  } key_state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 1000;
  localparam int unsigned LONG_DEFAULT     = 50_000_000;

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: one push-button channel (synchronizer, debounce FSM,
// hold counter). Long-press logic is built only with KEY_LONG_PRESS_EN.
module key_debounce_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic toggle,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          key_hi;
  key_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, toggle_n, press_n, rel_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign key_hi = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UP;
      cnt         <= '0;
      level       <= 1'b0;
      toggle      <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      level       <= level_n;
      toggle      <= toggle_n;
      press       <= press_n;
      release_evt <= rel_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    level_n  = level;
    toggle_n = toggle;
    press_n  = 1'b0;
    rel_n    = 1'b0;
    unique case (state)
      UP: begin
        if (!key_hi) begin
          state_n = PRESS_WAIT;
          cnt_n   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (key_hi) begin
          state_n = UP;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          state_n  = DOWN;
          cnt_n    = '0;
          press_n  = 1'b1;
          level_n  = 1'b1;
          toggle_n = !toggle;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DOWN: begin
        if (key_hi) begin
          state_n = REL_WAIT;
          cnt_n   = CW'(1);
        end
      end
      REL_WAIT: begin
        if (!key_hi) begin
          state_n = DOWN;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          state_n = UP;
          cnt_n   = '0;
          rel_n   = 1'b1;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = UP;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  logic [31:0] hold;
  logic        lp;

  // Hold count is zero outside a press and frozen while a release debounces.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      lp   <= 1'b0;
    end else begin
      lp <= 1'b0;
      unique case (state)
        UP, PRESS_WAIT: hold <= '0;
        DOWN: begin
          if (hold != '1) begin
            hold <= hold + 32'd1;
            lp   <= (hold + 32'd1) == 32'(LONG_CYCLES);
          end
        end
        default: hold <= hold;
      endcase
    end
  end

  assign long_press = lp;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: NKEYS independent debounced push-button channels.
// KEY_LONG_PRESS_EN enables long_press; "release" is a keyword, hence release_evt.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] level,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_evt,
  output logic [NKEYS-1:0] toggle,
  output logic [NKEYS-1:0] long_press
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[i]),
      .level      (level[i]),
      .press      (press[i]),
      .release_evt(release_evt[i]),
      .toggle     (toggle[i]),
      .long_press (long_press[i])
    );
  end

endmodule
